// File: rtl/dmem_access_pkg.sv
// Shared core package: memory-stage access FSM states and default ack timeout.
package dmem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam int unsigned DMEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/dmem_access.sv
// MEM-stage data-access controller: req/ack handshake to a variable-latency
// data memory, stalling the pipeline while the access is outstanding.
//
// state | meaning
// IDLE  | no access in flight; detect load/store from EX/MEM
// REQ   | request held on the memory port, waiting for ack or timeout
// DONE  | stall released, err_o pulses if misaligned/timed out
module dmem_access
  import dmem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

  dmem_state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_inc;
  logic        access;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    stall_o     = 1'b0;
    err_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    access      = start_i & (memread_i | memwrite_i);
    cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    unique case (state_q)
      IDLE: begin
        err_d   = 1'b0;
        stall_o = access;
        if (access) begin
          if (addr_i[1:0] == 2'b00) begin
            addr_d  = addr_i;
            wdata_d = wdata_i;
            we_d    = memwrite_i;
            cnt_d   = 8'd0;
            state_d = REQ;
          end else begin
            // misaligned: no memory request; a load reports zero data
            err_d = 1'b1;
            if (!memwrite_i) rdata_d = 32'h0;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        stall_o     = 1'b1;
        mem_req_o   = start_i;
        mem_we_o    = we_q;
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_wdata_o = wdata_q;
        cnt_d       = cnt_inc;
        // cnt_inc counts this REQ cycle, so TIMEOUT bounds the REQ cycles exactly
        if (mem_ack_i) begin
          if (!we_q) rdata_d = mem_rdata_i;
          state_d = DONE;
        end else if (cnt_inc == TIMEOUT_C) begin
          err_d = 1'b1;
          if (!we_q) rdata_d = 32'h0;
          state_d = DONE;
        end
      end
      DONE: begin
        err_o   = err_q;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!start_i) begin
      state_d = IDLE;
      err_d   = 1'b0;
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_access.sv
// Directed bench for dmem_access: vector table plus hand sequences for
// back-to-back, start drop, timeout and asynchronous reset.
module tb_dmem_access;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        memread_i;
  logic        memwrite_i;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  logic        stall_o, err_o, mem_req_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic        stall3, err3, req3, we3;
  logic [31:0] rdata3, addr3, wdata3;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  dmem_access dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  dmem_access #(.TIMEOUT(3)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .stall_o(stall3), .rdata_o(rdata3), .err_o(err3),
    .mem_req_o(req3), .mem_we_o(we3), .mem_addr_o(addr3),
    .mem_wdata_o(wdata3), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    int          lat;
    logic [31:0] mdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_stall;
    int          exp_req;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic resync();
    @(negedge clk_i);
    start_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    @(negedge clk_i);
    start_i = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int stalls, reqs, errs, badreq;
    logic done, got_err;
    logic [31:0] got_rdata;
    stalls = 0; reqs = 0; errs = 0; badreq = 0; done = 1'b0;
    got_err = 1'b0; got_rdata = 32'h0;
    @(negedge clk_i);
    addr_i = v.addr; wdata_i = v.wdata; memread_i = v.rd; memwrite_i = v.wr; start_i = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      if (c > 0) @(negedge clk_i);
      #1;
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      if (stall_o) stalls++;
      if (err_o) errs++;
      if (mem_req_o) begin
        reqs++;
        if (mem_addr_o !== v.addr || mem_we_o !== v.wr || (v.wr && mem_wdata_o !== v.wdata))
          badreq++;
        if (reqs == v.lat) begin
          mem_ack_i = 1'b1; mem_rdata_i = v.mdata;
        end
      end
      if (!stall_o) begin
        done = 1'b1; got_rdata = rdata_o; got_err = err_o;
        memread_i = 1'b0; memwrite_i = 1'b0;
      end
    end
    check($sformatf("v%0d_done", idx), 32'(done), 32'd1);
    check($sformatf("v%0d_stalls", idx), 32'(stalls), 32'(v.exp_stall));
    check($sformatf("v%0d_reqs", idx), 32'(reqs), 32'(v.exp_req));
    check($sformatf("v%0d_badreq", idx), 32'(badreq), 32'd0);
    check($sformatf("v%0d_errpulses", idx), 32'(errs), 32'(v.exp_err));
    check($sformatf("v%0d_err_done", idx), 32'(got_err), 32'(v.exp_err));
    check($sformatf("v%0d_rdata", idx), got_rdata, v.exp_rdata);
    resync();
  endtask

  initial begin
    int reqs, run, gap, mingap, dones, reqs3;
    logic prev_stall, seen3, done;
    logic [31:0] held, rd3;
    logic [31:0] b2b_addr[2];
    logic [31:0] b2b_data[2];

    vecs[0] = '{32'h100, 32'h0,        1'b1, 1'b0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2, 1};
    vecs[1] = '{32'h204, 32'h12345678, 1'b0, 1'b1, 4, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b0, 5, 4};
    vecs[2] = '{32'h102, 32'h0,        1'b1, 1'b0, 1, 32'h11111111, 32'h00000000, 1'b1, 1, 0};
    vecs[3] = '{32'h300, 32'h0,        1'b1, 1'b0, 3, 32'hA5A50F0F, 32'hA5A50F0F, 1'b0, 4, 3};
    vecs[4] = '{32'h301, 32'h77777777, 1'b0, 1'b1, 1, 32'h0,        32'hA5A50F0F, 1'b1, 1, 0};
    vecs[5] = '{32'h040, 32'hCAFEF00D, 1'b1, 1'b1, 2, 32'h99999999, 32'hA5A50F0F, 1'b0, 3, 2};
    vecs[6] = '{32'h000, 32'h0,        1'b1, 1'b0, 2, 32'h13579BDF, 32'h13579BDF, 1'b0, 3, 2};

    rst_i = 1'b0; start_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
    memread_i = 1'b0; memwrite_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_we", 32'(mem_we_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // back-to-back loads with L=2; the next load is presented as the first advances
    b2b_addr[0] = 32'h10; b2b_addr[1] = 32'h14;
    b2b_data[0] = 32'h1111AAAA; b2b_data[1] = 32'h2222BBBB;
    reqs = 0; run = 0; gap = 0; mingap = 99; dones = 0; prev_stall = 1'b0;
    @(negedge clk_i);
    addr_i = b2b_addr[0]; memread_i = 1'b1;
    for (int c = 0; c < 40 && dones < 2; c++) begin
      if (c > 0) @(negedge clk_i);
      #1;
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      if (mem_req_o) begin
        if (run == 0) begin
          reqs++;
          if (reqs > 1 && gap < mingap) mingap = gap;
          if (reqs <= 2) check($sformatf("b2b_addr%0d", reqs), mem_addr_o, b2b_addr[reqs-1]);
        end
        run++; gap = 0;
        if (run == 2 && reqs <= 2) begin
          mem_ack_i = 1'b1; mem_rdata_i = b2b_data[reqs-1];
        end
      end else begin
        run = 0; gap++;
      end
      if (!stall_o && prev_stall) begin
        dones++;
        check($sformatf("b2b_rdata%0d", dones), rdata_o, b2b_data[dones-1]);
        if (dones == 1) addr_i = b2b_addr[1];
        else memread_i = 1'b0;
      end
      prev_stall = stall_o;
    end
    check("b2b_dones", 32'(dones), 32'd2);
    check("b2b_reqs", 32'(reqs), 32'd2);
    check("b2b_gap_ge2", 32'(mingap >= 2), 32'd1);
    repeat (3) @(negedge clk_i);
    #1;
    check("b2b_no_extra_req", 32'(mem_req_o), 32'd0);
    resync();

    // start_i low mid-REQ abandons the access and keeps rdata_o
    held = rdata_o;
    @(negedge clk_i);
    addr_i = 32'h700; memread_i = 1'b1;
    @(negedge clk_i);
    #1;
    check("startlow_in_req", 32'(mem_req_o), 32'd1);
    start_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("startlow_req", 32'(mem_req_o), 32'd0);
    check("startlow_stall", 32'(stall_o), 32'd0);
    check("startlow_rdata", rdata_o, held);
    resync();

    // never-acked load: default instance 255 REQ cycles, TIMEOUT=3 instance 3
    reqs = 0; reqs3 = 0; seen3 = 1'b0; rd3 = 32'hFFFFFFFF; done = 1'b0;
    check("to_pre_rdata3_nonzero", 32'(rdata3 != 32'h0), 32'd1);
    @(negedge clk_i);
    addr_i = 32'h500; memread_i = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      if (c > 0) @(negedge clk_i);
      #1;
      if (mem_req_o) reqs++;
      if (!seen3) begin
        if (req3) reqs3++;
        if (err3) begin seen3 = 1'b1; rd3 = rdata3; end
      end
      if (!stall_o) begin
        done = 1'b1;
        check("to_err", 32'(err_o), 32'd1);
        check("to_rdata", rdata_o, 32'h0);
        memread_i = 1'b0;
      end
    end
    check("to_done", 32'(done), 32'd1);
    check("to_reqs_default", 32'(reqs), 32'd255);
    check("to3_seen_err", 32'(seen3), 32'd1);
    check("to3_reqs", 32'(reqs3), 32'd3);
    check("to3_rdata", rd3, 32'h0);
    resync();

    // async reset in the 2nd REQ cycle of a store
    reqs = 0;
    @(negedge clk_i);
    addr_i = 32'h600; wdata_i = 32'h55AA55AA; memwrite_i = 1'b1;
    for (int c = 0; c < 10 && reqs < 2; c++) begin
      @(negedge clk_i);
      #1;
      if (mem_req_o) reqs++;
    end
    check("rstreq_reached", 32'(reqs), 32'd2);
    check("rstreq_we_before", 32'(mem_we_o), 32'd1);
    rst_i = 1'b0; memwrite_i = 1'b0;
    #1;
    check("rstreq_req", 32'(mem_req_o), 32'd0);
    check("rstreq_stall", 32'(stall_o), 32'd0);
    check("rstreq_we", 32'(mem_we_o), 32'd0);
    check("rstreq_addr", mem_addr_o, 32'h0);
    check("rstreq_wdata", mem_wdata_o, 32'h0);
    check("rstreq_rdata", rdata_o, 32'h0);
    check("rstreq_err", 32'(err_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    check("post_rst_idle_req", 32'(mem_req_o), 32'd0);
    check("post_rst_idle_stall", 32'(stall_o), 32'd0);
    run_vec('{32'h080, 32'h0, 1'b1, 1'b0, 1, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 2, 1}, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access.md
# dmem_access

Memory-stage data-access controller for the pipelined RISC-V core. It sits directly downstream of the EX/MEM pipeline register. It takes that register's ALU result (address), RS2 data (store data) and MemRead/MemWrite controls, and runs a request/acknowledge transaction to a variable-latency data memory. While the access is outstanding it stalls the pipeline, then presents load data to the MEM/WB register.

## Interface
- `TIMEOUT`, default 255: maximum cycles in `REQ` waiting for `mem_ack_i` before aborting; range 1..255.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  core run enable; low forces synchronous return to `IDLE`.
- `addr_i`  in  32  ALU result from EX/MEM; byte address.
- `wdata_i`  in  32  RS2 data from EX/MEM.
- `memread_i`  in  1  load request from EX/MEM.
- `memwrite_i`  in  1  store request from EX/MEM.
- `stall_o`  out  1  hold PC, IF/ID, ID/EX and EX/MEM; bubble into MEM/WB.
- `rdata_o`  out  32  load data to MEM/WB.
- `err_o`  out  1  one-cycle pulse in `DONE`: misaligned access or timeout.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  1 = write, 0 = read; valid while `mem_req_o` is high.
- `mem_addr_o`  out  32  word address; bits [1:0] are always 0.
- `mem_wdata_o`  out  32  store data.
- `mem_ack_i`  in  1  memory completion. For reads, `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i`  in  32  read data.

## Operation
- `access = start_i & (memread_i | memwrite_i)`. If both request bits are high, the access is treated as a write.
- State `IDLE`:
  - If `access` is high and `addr_i[1:0] == 0`: latch address, data and `we`; go to `REQ`.
  - If `access` is high and misaligned: go to `DONE` with an error flag; no memory request is issued.
- State `REQ`:
  - `mem_req_o = 1`; address, data and `we` are driven from the latched values, which stay stable.
  - On `mem_ack_i`: for a read, capture `mem_rdata_i` into `rdata_o`; go to `DONE`.
  - On timeout counter `== TIMEOUT` with no ack: set the error flag; for a read, `rdata_o` becomes 0; go to `DONE`.
- State `DONE`: `stall_o = 0` and `err_o` = error flag; always returns to `IDLE`. The held instruction is not reissued.
- `stall_o = (IDLE & access) | REQ`. This is combinational so that EX/MEM holds in the detection cycle.
- `rdata_o` holds its value until the next completed or aborted load. Stores and misaligned stores never change it. A misaligned load sets `rdata_o` to 0.
- Timeout counter: 8 bits, cleared on entry to `REQ`, incremented each `REQ` cycle, saturating.
- `start_i` low in any state: next state is `IDLE`, `mem_req_o` drops, error flag clears; `rdata_o` is retained.

## Timing
- Reset values: state `IDLE`, `stall_o` 0 (with `memread_i`/`memwrite_i` low), `rdata_o` 0, `err_o` 0, `mem_req_o` 0, `mem_we_o` 0, `mem_addr_o` 0, `mem_wdata_o` 0, counter 0.
- Aligned access with ack latency L (ack in the L-th `REQ` cycle, L ≥ 1):
  - cycle 0: `IDLE`, `stall_o` = 1.
  - cycles 1..L: `REQ`, `stall_o` = 1.
  - cycle L+1: `DONE`, `stall_o` = 0; the instruction advances on that cycle's edge.
  - Total: L+1 stall cycles.
- Misaligned access: 1 stall cycle, then `DONE`.
- `mem_ack_i` outside `REQ` is ignored.
- Reset asserted mid-`REQ`: `mem_req_o` drops immediately (asynchronously); the transaction is abandoned.
- Back-to-back accesses: the next access is detected in the cycle after `DONE`. `mem_req_o` is low for at least 2 cycles between requests.

## Structure
- The shared core package holds the state enum (`IDLE`, `REQ`, `DONE`) and the `DMEM_TIMEOUT_DEFAULT` constant.
- Single module with no sub-modules. The FSM, latch registers and counter sit in one asynchronous-reset sequential process; `stall_o` and the memory outputs are produced by a combinational process.

## Test plan
- Load `addr_i` = 0x100, ack at L=1 with `mem_rdata_i` = 0xDEADBEEF → `mem_addr_o` = 0x100 and `mem_we_o` = 0; `stall_o` high for 2 cycles; `rdata_o` = 0xDEADBEEF in `DONE`; `err_o` = 0.
- Store `addr_i` = 0x204, `wdata_i` = 0x12345678, ack at L=4 → `mem_we_o` = 1 and `mem_wdata_o` = 0x12345678 stable for 4 cycles; 5 stall cycles; `rdata_o` unchanged.
- Load `addr_i` = 0x102 → no `mem_req_o`; 1 stall cycle; `err_o` pulses once; `rdata_o` = 0.
- `TIMEOUT` = 3, load, ack never comes → exactly 3 `REQ` cycles, then `DONE` with `err_o` = 1 and `rdata_o` = 0.
- Two back-to-back loads, each with L=2 → each produces exactly one request; no duplicate request from the `DONE` cycle.
- `rst_i` low in the 2nd `REQ` cycle → all outputs return to reset values without waiting for a clock edge; after release, the FSM is in `IDLE`.
